uart_alu_pkt_parser: RTL

- Sits inside uart_alu, directly downstream of the uart_rx byte stream (8-bit AXI-Stream).
- Parses packets of the form: opcode, reserved, length LSB, length MSB, then payload.
- Emits either little-endian 32-bit operands for the ALU datapath (add/mul/div) or raw payload bytes for the echo path.
- Detects bad opcodes and bad lengths; drains the rest of the packet so the stream re-aligns on the next header.

---
 rtl/uart_alu_pkt_parser.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/uart_alu_pkt_parser.sv
// Packet parser between uart_rx and the ALU: decodes the 4-byte header, assembles
// little-endian 32-bit operands or forwards echo payload, and drains bad packets.
module uart_alu_pkt_parser #(
  parameter logic [7:0] ECHO_OP = 8'hEC,
  parameter logic [7:0] ADD_OP  = 8'h01,
  parameter logic [7:0] MUL_OP  = 8'h02,
  parameter logic [7:0] DIV_OP  = 8'h03
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [7:0]  s_axis_tdata,
  input  logic        s_axis_tvalid,
  output logic        s_axis_tready,
  output logic [31:0] m_op_tdata,
  output logic        m_op_tvalid,
  input  logic        m_op_tready,
  output logic        m_op_tlast,
  output logic [7:0]  m_op_opcode,
  output logic [7:0]  m_echo_tdata,
  output logic        m_echo_tvalid,
  input  logic        m_echo_tready,
  output logic        m_echo_tlast,
  output logic        err_o,
  output logic [1:0]  err_code_o,
  output logic        busy_o
);

  typedef enum logic [2:0] {
    S_IDLE, S_RSVD, S_LEN_LO, S_LEN_HI, S_ALU, S_ECHO, S_DRAIN
  } state_t;

  localparam logic [1:0] ERR_OPCODE = 2'b01;
  localparam logic [1:0] ERR_LENGTH = 2'b10;

  state_t      state_q;
  logic [7:0]  opcode_q;
  logic [7:0]  op_opcode_q;
  logic [7:0]  len_lo_q;
  logic [15:0] rem_q;
  logic [1:0]  byte_idx_q;
  logic [23:0] asm_q;
  logic [31:0] op_data_q;
  logic        op_valid_q;
  logic        op_last_q;
  logic [7:0]  echo_data_q;
  logic        echo_valid_q;
  logic        echo_last_q;
  logic        err_q;
  logic [1:0]  err_code_q;

  logic [15:0] len_d;
  logic [15:0] rem_len_d;
  logic [15:0] rem_dec_d;
  logic        is_alu_op;
  logic        accept;
  logic        op_take;
  logic        echo_take;

  always_comb begin
    len_d     = {s_axis_tdata, len_lo_q};
    rem_len_d = len_d - 16'd4;
    rem_dec_d = rem_q - 16'd1;
    is_alu_op = (opcode_q == ADD_OP) || (opcode_q == MUL_OP) || (opcode_q == DIV_OP);
    op_take   = op_valid_q && m_op_tready;
    echo_take = echo_valid_q && m_echo_tready;
  end

  // Only the 4th operand byte needs a free output slot; bytes 1-3 go to asm_q.
  always_comb begin
    case (state_q)
      S_ALU:   s_axis_tready = !(op_valid_q && !m_op_tready) || (byte_idx_q != 2'd3);
      S_ECHO:  s_axis_tready = !echo_valid_q || m_echo_tready;
      default: s_axis_tready = 1'b1;
    endcase
  end

  assign accept = s_axis_tvalid && s_axis_tready;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= S_IDLE;
      opcode_q     <= 8'h00;
      op_opcode_q  <= 8'h00;
      len_lo_q     <= 8'h00;
      rem_q        <= 16'h0000;
      byte_idx_q   <= 2'd0;
      asm_q        <= 24'h000000;
      op_data_q    <= 32'h0000_0000;
      op_valid_q   <= 1'b0;
      op_last_q    <= 1'b0;
      echo_data_q  <= 8'h00;
      echo_valid_q <= 1'b0;
      echo_last_q  <= 1'b0;
      err_q        <= 1'b0;
      err_code_q   <= 2'b00;
    end else begin
      err_q <= 1'b0;
      if (op_take)   op_valid_q   <= 1'b0;
      if (echo_take) echo_valid_q <= 1'b0;
      if (accept) begin
        case (state_q)
          S_IDLE: begin
            opcode_q <= s_axis_tdata;
            state_q  <= S_RSVD;
          end
          S_RSVD: state_q <= S_LEN_LO;
          S_LEN_LO: begin
            len_lo_q <= s_axis_tdata;
            state_q  <= S_LEN_HI;
          end
          S_LEN_HI: begin
            op_opcode_q <= opcode_q;
            rem_q       <= rem_len_d;
            byte_idx_q  <= 2'd0;
            if (len_d < 16'd4) begin
              err_q      <= 1'b1;
              err_code_q <= ERR_LENGTH;
              state_q    <= S_IDLE;
            end else if (is_alu_op) begin
              if ((len_d < 16'd8) || (rem_len_d[1:0] != 2'd0)) begin
                err_q      <= 1'b1;
                err_code_q <= ERR_LENGTH;
                state_q    <= (rem_len_d == 16'd0) ? S_IDLE : S_DRAIN;
              end else begin
                state_q <= S_ALU;
              end
            end else if (opcode_q == ECHO_OP) begin
              state_q <= (rem_len_d == 16'd0) ? S_IDLE : S_ECHO;
            end else begin
              err_q      <= 1'b1;
              err_code_q <= ERR_OPCODE;
              state_q    <= (rem_len_d == 16'd0) ? S_IDLE : S_DRAIN;
            end
          end
          S_ALU: begin
            rem_q      <= rem_dec_d;
            byte_idx_q <= byte_idx_q + 2'd1;
            case (byte_idx_q)
              2'd0: asm_q[7:0]   <= s_axis_tdata;
              2'd1: asm_q[15:8]  <= s_axis_tdata;
              2'd2: asm_q[23:16] <= s_axis_tdata;
              default: begin
                op_data_q  <= {s_axis_tdata, asm_q};
                op_valid_q <= 1'b1;
                op_last_q  <= (rem_dec_d == 16'd0);
              end
            endcase
            if (rem_dec_d == 16'd0) state_q <= S_IDLE;
          end
          S_ECHO: begin
            rem_q        <= rem_dec_d;
            echo_data_q  <= s_axis_tdata;
            echo_valid_q <= 1'b1;
            echo_last_q  <= (rem_dec_d == 16'd0);
            if (rem_dec_d == 16'd0) state_q <= S_IDLE;
          end
          S_DRAIN: begin
            rem_q <= rem_dec_d;
            if (rem_dec_d == 16'd0) state_q <= S_IDLE;
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign m_op_tdata    = op_data_q;
  assign m_op_tvalid   = op_valid_q;
  assign m_op_tlast    = op_last_q;
  assign m_op_opcode   = op_opcode_q;
  assign m_echo_tdata  = echo_data_q;
  assign m_echo_tvalid = echo_valid_q;
  assign m_echo_tlast  = echo_last_q;
  assign err_o         = err_q;
  assign err_code_o    = err_code_q;
  assign busy_o        = (state_q != S_IDLE);

endmodule
